// File: rtl/matmul_sched_if.sv
// Operand-memory read port and result valid/ready port of matmul_sched.
// master = scheduler side, slave = memories plus result consumer.
interface matmul_sched_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned INNER      = 4,
    parameter int unsigned COLS       = 4
);
    localparam int unsigned AAddrW = (ROWS * INNER > 1) ? $clog2(ROWS * INNER) : 1;
    localparam int unsigned BAddrW = (INNER * COLS > 1) ? $clog2(INNER * COLS) : 1;
    localparam int unsigned RowW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned ColW   = (COLS > 1) ? $clog2(COLS) : 1;

    logic                         rd_en;
    logic [AAddrW-1:0]            a_addr;
    logic [BAddrW-1:0]            b_addr;
    logic signed [DATA_WIDTH-1:0] a_data;
    logic signed [DATA_WIDTH-1:0] b_data;
    logic                         res_valid;
    logic                         res_ready;
    logic signed [DATA_WIDTH-1:0] res_data;
    logic [RowW-1:0]              res_row;
    logic [ColW-1:0]              res_col;

    modport master (
        output rd_en, a_addr, b_addr, res_valid, res_data, res_row, res_col,
        input  a_data, b_data, res_ready
    );

    modport slave (
        input  rd_en, a_addr, b_addr, res_valid, res_data, res_row, res_col,
        output a_data, b_data, res_ready
    );
endinterface

// File: rtl/matmul_sched.sv
// Matrix-product sequencer: one shared MAC walks every C[i][j] in row-major order.
// Define MATMUL_SCHED_SAT_EN to clamp results to DATA_WIDTH instead of wrapping.
module matmul_sched #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned INNER      = 4,
    parameter int unsigned COLS       = 4
) (
    input  logic           clk_i,
    input  logic           reset_ni,
    input  logic           start_i,
    output logic           busy_o,
    output logic           done_o,
    matmul_sched_if.master bus
);
    localparam int unsigned AccW   = 2 * DATA_WIDTH + $clog2(INNER);
    localparam int unsigned AAddrW = (ROWS * INNER > 1) ? $clog2(ROWS * INNER) : 1;
    localparam int unsigned BAddrW = (INNER * COLS > 1) ? $clog2(INNER * COLS) : 1;
    localparam int unsigned RowW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned ColW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned KW     = (INNER > 1) ? $clog2(INNER) : 1;

    typedef enum logic [2:0] {StIdle, StFetch, StDrain, StOut, StDone} state_e;

    state_e                       state_q, state_d;
    logic [RowW-1:0]              i_q, i_d;
    logic [ColW-1:0]              j_q, j_d;
    logic [KW-1:0]                k_q, k_d;
    logic signed [AccW-1:0]       acc_q, acc_d;
    logic                         rd_q, rd_d;
    logic [AAddrW-1:0]            a_addr_q, a_addr_d;
    logic [BAddrW-1:0]            b_addr_q, b_addr_d;
    logic signed [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic [RowW-1:0]              res_row_q, res_row_d;
    logic [ColW-1:0]              res_col_q, res_col_d;

    logic                           rd_en;
    logic [AAddrW-1:0]              a_addr_now;
    logic [BAddrW-1:0]              b_addr_now;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [DATA_WIDTH-1:0]   res_clip;

    assign a_addr_now = AAddrW'(int'(i_q) * int'(INNER) + int'(k_q));
    assign b_addr_now = BAddrW'(int'(k_q) * int'(COLS) + int'(j_q));
    assign prod       = bus.a_data * bus.b_data;

`ifdef MATMUL_SCHED_SAT_EN
    localparam logic signed [AccW-1:0] SatMax =
        {{(AccW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin =
        {{(AccW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    always_comb begin
        if (acc_d > SatMax) begin
            res_clip = SatMax[DATA_WIDTH-1:0];
        end else if (acc_d < SatMin) begin
            res_clip = SatMin[DATA_WIDTH-1:0];
        end else begin
            res_clip = acc_d[DATA_WIDTH-1:0];
        end
    end
`else
    assign res_clip = acc_d[DATA_WIDTH-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        acc_d      = acc_q;
        rd_d       = 1'b0;
        a_addr_d   = a_addr_q;
        b_addr_d   = b_addr_q;
        res_data_d = res_data_q;
        res_row_d  = res_row_q;
        res_col_d  = res_col_q;
        rd_en      = 1'b0;

        // Operands return one cycle after the strobe, so the MAC lags the read by one.
        if (rd_q) begin
            acc_d = acc_q + AccW'(prod);
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            StFetch: begin
                rd_en    = 1'b1;
                rd_d     = 1'b1;
                a_addr_d = a_addr_now;
                b_addr_d = b_addr_now;
                if (k_q == KW'(INNER - 1)) begin
                    k_d     = '0;
                    state_d = StDrain;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDrain: begin
                state_d    = StOut;
                res_data_d = res_clip;
                res_row_d  = i_q;
                res_col_d  = j_q;
            end
            StOut: begin
                if (bus.res_ready) begin
                    if (i_q == RowW'(ROWS - 1) && j_q == ColW'(COLS - 1)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StFetch;
                        k_d     = '0;
                        acc_d   = '0;
                        if (j_q == ColW'(COLS - 1)) begin
                            j_d = '0;
                            i_d = i_q + 1'b1;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            rd_q       <= 1'b0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            res_data_q <= '0;
            res_row_q  <= '0;
            res_col_q  <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            rd_q       <= rd_d;
            a_addr_q   <= a_addr_d;
            b_addr_q   <= b_addr_d;
            res_data_q <= res_data_d;
            res_row_q  <= res_row_d;
            res_col_q  <= res_col_d;
        end
    end

    // Control outputs are gated by reset so they drop in the cycle reset is sampled.
    assign bus.rd_en     = rd_en && reset_ni;
    assign bus.res_valid = (state_q == StOut) && reset_ni;
    assign busy_o        = (state_q != StIdle) && reset_ni;
    assign done_o        = (state_q == StDone) && reset_ni;

    assign bus.a_addr   = rd_en ? a_addr_now : a_addr_q;
    assign bus.b_addr   = rd_en ? b_addr_now : b_addr_q;
    assign bus.res_data = res_data_q;
    assign bus.res_row  = res_row_q;
    assign bus.res_col  = res_col_q;
endmodule
